// File: rtl/hazard_stall_controller.sv
// Load-use stall / taken-branch flush sequencer for the 5-stage RV64 pipeline.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush event counters.
module hazard_stall_controller #(
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IF_ID_valid,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic             branch_taken,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LOAD_LATENCY - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;

    always_comb begin
        load_use = IF_ID_valid & ID_EX_MemRead & (ID_EX_rd != 5'd0) &
                   ((IF_ID_use_rs1 & (IF_ID_rs1 == ID_EX_rd)) |
                    (IF_ID_use_rs2 & (IF_ID_rs2 == ID_EX_rd)));
    end

    // Branch squash outranks any stall; outputs are forced to idle while reset is held.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        if (!reset) begin
            state_d = RUN;
            cnt_d   = 4'd0;
        end else if (branch_taken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            state_d      = RUN;
            cnt_d        = 4'd0;
        end else if (state_q == STALL) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            cnt_d        = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = RUN;
            end
        end else if (load_use) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            if (LOAD_LATENCY > 1) begin
                state_d = STALL;
                cnt_d   = CNT_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_active = (state_q == STALL);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!PC_Write && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (branch_taken && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: three controllers (latency 1, latency 3, latency 1 with 2-bit counters) share one stimulus stream.
module tb_hazard_stall_controller;

    logic       clk;
    logic       reset;
    logic       IF_ID_valid;
    logic [4:0] IF_ID_rs1;
    logic [4:0] IF_ID_rs2;
    logic       IF_ID_use_rs1;
    logic       IF_ID_use_rs2;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_rd;
    logic       branch_taken;

    logic        pc1, ifw1, bub1, iff1, idf1, exf1, sa1;
    logic        pc3, ifw3, bub3, iff3, idf3, exf3, sa3;
    logic        pcs, ifws, bubs, iffs, idfs, exfs, sas;
    logic [31:0] sc1, fc1, sc3, fc3;
    logic [1:0]  scs, fcs;

    int checks   = 0;
    int failures = 0;

    // {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, stall_active}
    localparam logic [6:0] RUNV = 7'b1100000;
    localparam logic [6:0] STL  = 7'b0010000;
    localparam logic [6:0] STLA = 7'b0010001;
    localparam logic [6:0] FLS  = 7'b1101110;
    localparam logic [6:0] FLSA = 7'b1101111;

    logic [6:0] o1, o3, os;
    assign o1 = {pc1, ifw1, bub1, iff1, idf1, exf1, sa1};
    assign o3 = {pc3, ifw3, bub3, iff3, idf3, exf3, sa3};
    assign os = {pcs, ifws, bubs, iffs, idfs, exfs, sas};

    hazard_stall_controller #(.LOAD_LATENCY(1), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset), .IF_ID_valid(IF_ID_valid), .IF_ID_rs1(IF_ID_rs1),
        .IF_ID_rs2(IF_ID_rs2), .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd), .branch_taken(branch_taken),
        .PC_Write(pc1), .IF_ID_Write(ifw1), .ID_EX_Bubble(bub1), .IF_ID_Flush(iff1),
        .ID_EX_Flush(idf1), .EX_MEM_Flush(exf1), .stall_active(sa1),
        .stall_count(sc1), .flush_count(fc1)
    );

    hazard_stall_controller #(.LOAD_LATENCY(3), .CNT_W(32)) u3 (
        .clk(clk), .reset(reset), .IF_ID_valid(IF_ID_valid), .IF_ID_rs1(IF_ID_rs1),
        .IF_ID_rs2(IF_ID_rs2), .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd), .branch_taken(branch_taken),
        .PC_Write(pc3), .IF_ID_Write(ifw3), .ID_EX_Bubble(bub3), .IF_ID_Flush(iff3),
        .ID_EX_Flush(idf3), .EX_MEM_Flush(exf3), .stall_active(sa3),
        .stall_count(sc3), .flush_count(fc3)
    );

    hazard_stall_controller #(.LOAD_LATENCY(1), .CNT_W(2)) us (
        .clk(clk), .reset(reset), .IF_ID_valid(IF_ID_valid), .IF_ID_rs1(IF_ID_rs1),
        .IF_ID_rs2(IF_ID_rs2), .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd), .branch_taken(branch_taken),
        .PC_Write(pcs), .IF_ID_Write(ifws), .ID_EX_Bubble(bubs), .IF_ID_Flush(iffs),
        .ID_EX_Flush(idfs), .EX_MEM_Flush(exfs), .stall_active(sas),
        .stall_count(scs), .flush_count(fcs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters read as zero unless the performance-counter build is selected.
    function automatic logic [31:0] ec(input int n);
`ifdef HAZARD_PERF_CNT_EN
        return 32'(n);
`else
        return 32'(0 * n);
`endif
    endfunction

    function automatic logic [31:0] ecs(input int n);
        return (ec(n) > 32'd3) ? 32'd3 : ec(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [6:0] e1, input logic [6:0] e3,
                           input int s1, input int s3, input int f);
        chk({tag, "_out1"}, 32'(o1), 32'(e1));
        chk({tag, "_out3"}, 32'(o3), 32'(e3));
        chk({tag, "_outs"}, 32'(os), 32'(e1));
        chk({tag, "_sc1"}, sc1, ec(s1));
        chk({tag, "_sc3"}, sc3, ec(s3));
        chk({tag, "_scs"}, 32'(scs), ecs(s1));
        chk({tag, "_fc1"}, fc1, ec(f));
        chk({tag, "_fc3"}, fc3, ec(f));
        chk({tag, "_fcs"}, 32'(fcs), ecs(f));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        IF_ID_valid   = 1'b1;
        IF_ID_rs1     = 5'd5;
        IF_ID_rs2     = 5'd0;
        IF_ID_use_rs1 = 1'b1;
        IF_ID_use_rs2 = 1'b0;
        ID_EX_MemRead = 1'b1;
        ID_EX_rd      = 5'd5;
        branch_taken  = 1'b0;

        // Reset held with a hazard pending: outputs must sit at reset values.
        tick();
        chk_all("rst", RUNV, RUNV, 0, 0, 0);
        tick();
        reset = 1'b1;
        #1;
        // A: ld x5 / add rs1=x5
        chk_all("A", STL, STL, 0, 0, 0);
        tick();
        ID_EX_MemRead = 1'b0;
        #1;
        chk_all("B", RUNV, STLA, 1, 1, 0);
        tick();
        chk_all("C", RUNV, STLA, 1, 2, 0);
        tick();
        chk_all("D", RUNV, RUNV, 1, 3, 0);

        // No-stall patterns
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0;
        #1;
        chk_all("x0", RUNV, RUNV, 1, 3, 0);
        ID_EX_rd = 5'd7; IF_ID_rs1 = 5'd3; IF_ID_rs2 = 5'd7; IF_ID_use_rs2 = 1'b0;
        #1;
        chk_all("rs2off", RUNV, RUNV, 1, 3, 0);
        IF_ID_use_rs2 = 1'b1; IF_ID_valid = 1'b0;
        #1;
        chk_all("invalid", RUNV, RUNV, 1, 3, 0);
        IF_ID_valid = 1'b1; ID_EX_MemRead = 1'b0;
        #1;
        chk_all("noload", RUNV, RUNV, 1, 3, 0);

        // E: rs2 hazard, held across edges for back-to-back stalls
        tick();
        ID_EX_MemRead = 1'b1;
        #1;
        chk_all("E", STL, STL, 1, 3, 0);
        tick();
        chk_all("F", STL, STLA, 2, 4, 0);
        tick();
        chk_all("G", STL, STLA, 3, 5, 0);
        tick();
        chk_all("H", STL, STL, 4, 6, 0);
        tick();
        chk_all("I", STL, STLA, 5, 7, 0);
        tick();
        branch_taken = 1'b1;
        #1;
        chk_all("J", FLS, FLSA, 6, 8, 0);
        tick();
        branch_taken  = 1'b0;
        ID_EX_MemRead = 1'b0;
        #1;
        chk_all("K", RUNV, RUNV, 6, 8, 1);

        // Async reset mid-STALL
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd5; IF_ID_use_rs2 = 1'b0;
        #1;
        chk_all("L", STL, STL, 6, 8, 1);
        tick();
        chk_all("M", STL, STLA, 7, 9, 1);
        reset = 1'b0;
        #1;
        chk_all("arst", RUNV, RUNV, 0, 0, 0);
        tick();
        chk_all("arst_hold", RUNV, RUNV, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk_all("rel", STL, STL, 0, 0, 0);
        tick();
        ID_EX_MemRead = 1'b0;
        #1;
        chk_all("rel2", RUNV, STLA, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
